// File: rtl/pcileech_header.sv
// Shared definitions for the CFG response path: packer FSM states and default filler word.
package pcileech_header;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } cfg_pack_state_t;

  localparam logic [31:0] CFG_FILLER_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/pcileech_cfg_rsp_pack.sv
// Packs pairs of 32-bit CFG responses into one 64-bit FT601 word {newer, older};
// a lone response is flushed with a filler upper slot after FLUSH_TICKS cycles.
module pcileech_cfg_rsp_pack
  import pcileech_header::*;
#(
  parameter int unsigned FLUSH_TICKS = 64,
  parameter logic [31:0] FILLER      = CFG_FILLER_DEFAULT
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  output logic        rx_rd_en,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic [63:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] rsp_count,
  output logic        ovf
);

  localparam logic [15:0] TMAX = 16'(FLUSH_TICKS - 1);

  cfg_pack_state_t state, state_nxt;
  logic [31:0] lo, lo_nxt;
  logic [15:0] timer, timer_nxt;
  logic [63:0] data_nxt;
  logic        rd_pend;
  logic        run;
  logic        acc;
  logic        ovf_set;

  // run holds reads off until the first edge after reset release
  assign rx_rd_en = run & ~rd_pend &
                    ((state == EMPTY) | ((state == HALF) & (timer < TMAX)));

  always_comb begin
    state_nxt = state;
    lo_nxt    = lo;
    timer_nxt = timer;
    data_nxt  = out_data;
    acc       = 1'b0;
    ovf_set   = 1'b0;
    case (state)
      EMPTY: begin
        if (rx_valid) begin
          lo_nxt    = rx_data;
          timer_nxt = '0;
          acc       = 1'b1;
          state_nxt = HALF;
        end
      end
      HALF: begin
        if (rx_valid) begin
          data_nxt  = {rx_data, lo};
          acc       = 1'b1;
          state_nxt = FULL;
        end else if (timer == TMAX) begin
          // a read still in flight may yet deliver the partner
          if (!rd_pend) begin
            data_nxt  = {FILLER, lo};
            state_nxt = FULL;
          end
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end
      FULL: begin
        if (rx_valid) ovf_set = 1'b1;
        if (out_ready) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      lo        <= '0;
      timer     <= '0;
      rd_pend   <= 1'b0;
      run       <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      rsp_count <= '0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      lo        <= lo_nxt;
      timer     <= timer_nxt;
      rd_pend   <= rx_rd_en;
      run       <= 1'b1;
      out_data  <= data_nxt;
      out_valid <= (state_nxt == FULL);
      if (acc) rsp_count <= rsp_count + 16'd1;
      if (ovf_set) ovf <= 1'b1;
    end
  end

endmodule

// File: doc/pcileech_cfg_rsp_pack.md
PCILEECH_CFG_RSP_PACK -- requirements
Module: pcileech_cfg_rsp_pack

Interface
REQ-001 SHALL have parameter FLUSH_TICKS, default 64: clk_sys cycles a lone response waits for a partner before it is flushed; legal range 2..65535.
REQ-002 SHALL have parameter FILLER, default 32'hFFFF_FFFF: value placed in an unpaired upper slot.
REQ-003 SHALL have port clk_sys, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rx_rd_en, output, 1 bit: read strobe to the CFG response FIFO.
REQ-006 SHALL have port rx_data, input, 32 bits: CFG response word, [31:16] address byte, [15:0] byte-swapped data.
REQ-007 SHALL have port rx_valid, input, 1 bit: rx_data is valid; it arrives exactly 1 cycle after an rx_rd_en on a non-empty FIFO.
REQ-008 SHALL have port out_data, output, 64 bits: packed word {upper slot, lower slot} to the FT601 TX mux.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is offered.
REQ-010 SHALL have port out_ready, input, 1 bit: mux accepts out_data in this cycle.
REQ-011 SHALL have port rsp_count, output, 16 bits: responses accepted, wraps modulo 2^16.
REQ-012 SHALL have port ovf, output, 1 bit: sticky flag, set when rx_valid arrives with no free slot.

Function
REQ-013 SHALL implement FSM states EMPTY, HALF, FULL, with a lower-slot register lo[31:0], a timer[15:0] and a flag rd_pend, where rd_pend is rx_rd_en registered.
REQ-014 SHALL drive rx_rd_en = ~rd_pend & ((state==EMPTY) | (state==HALF & timer < FLUSH_TICKS-1)), so at most one read is in flight and reads occur at most every 2nd cycle.
REQ-015 In EMPTY with rx_valid, SHALL capture lo<=rx_data, clear the timer and move to HALF.
REQ-016 In HALF with rx_valid, SHALL set out_data<={rx_data,lo} and move to FULL next cycle.
REQ-017 In HALF without rx_valid, SHALL increment the timer, saturating at FLUSH_TICKS-1.
REQ-018 In HALF, when timer==FLUSH_TICKS-1 & ~rd_pend & ~rx_valid, SHALL set out_data<={FILLER,lo} and move to FULL.
REQ-019 In FULL, SHALL hold out_valid=1 with out_data stable until out_ready, and return to EMPTY in the cycle after out_ready is sampled high.
REQ-020 out_valid SHALL be a registered output equal to (state==FULL); latency from the 2nd rx_valid to out_valid is 1 cycle.
REQ-021 SHALL increment rsp_count by 1 on every rx_valid accepted in EMPTY or HALF.
REQ-022 On rx_valid while in FULL, SHALL discard the data, set ovf and leave the state unchanged.
REQ-023 SHALL place lower slot = older response and upper slot = newer response; no response SHALL be reordered or duplicated.

Reset
REQ-024 When rst_n is low, SHALL asynchronously force: state=EMPTY, lo=0, timer=0, rd_pend=0, out_data=0, out_valid=0, rx_rd_en=0, rsp_count=0, ovf=0.
REQ-025 SHALL deassert reset synchronously to clk_sys; a response held mid-operation at reset is lost, and the first rx_rd_en comes no earlier than the 1st edge after rst_n rises.

Structure
REQ-026 SHALL take the state enum (EMPTY/HALF/FULL) and the default FILLER constant from the shared pcileech_header package.
REQ-027 SHALL be a single flat module with no sub-module; the timer is inline.

Verification
REQ-028 Two responses 32'h8010_3412 then 32'h8012_7856, out_ready=1 -> one out_data 64'h8012_7856_8010_3412, out_valid high for 1 cycle, rsp_count=2.
REQ-029 Single response 32'h0004_0100, no further data, FLUSH_TICKS=64 -> out_data 64'hFFFF_FFFF_0004_0100 about 64 cycles after capture, and rx_rd_en low from timer==63.
REQ-030 FULL with out_ready=0 for 20 cycles -> out_valid and out_data stable, rx_rd_en=0 throughout, and no read occurs.
REQ-031 Continuous FIFO data for 100 responses -> 50 packed words in order, rx_rd_en never high on consecutive cycles, and ovf=0.
REQ-032 rst_n pulled low while in HALF -> all outputs are 0 within the same cycle, and after release the next pair packs correctly.
REQ-033 Forced rx_valid injected in FULL -> ovf=1 sticky, out_data unchanged, rsp_count unchanged.
